// File: rtl/adder_disp_pkg.sv
// Shared types and constants for the adder result display stage.
package adder_disp_pkg;

    localparam int DIGIT_W = 4;
    localparam int SUM_W   = 5;

    // Conversion FSM states.
    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    // Active-low seven-segment patterns, bit6..bit0 = g..a.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Non-decimal inputs produce a blank display.
module seg7_decoder
    import adder_disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [6:0]         seg_o
);

    // Digit lookup; every path assigns seg_o so no latch can form.
    always_comb begin
        // NOTE: a default assignment first keeps combinational logic latch-free.
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/adder_result_display.sv
// Captures the adder sum on a synchronised LOAD rising edge, converts it to
// two decimal digits by repeated subtraction of ten, and drives two
// active-low seven-segment displays plus an LED echo of the captured value.
// Optional macro LEADING_ZERO_BLANK_EN blanks HEX1 when the tens digit is 0.
module adder_result_display
    import adder_disp_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [SUM_W-1:0] SUM,
    input  logic             LOAD,
    output logic [SUM_W-1:0] LEDR,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX0,
    output logic             BUSY,
    output logic             VALID
);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] HEX1_RST = SEG_BLANK;
`else
    localparam logic [6:0] HEX1_RST = SEG_0;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   load_dly_q;
    logic                   load_rise;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   rem_q, rem_d;
    logic [1:0]         tens_q, tens_d;
    logic [SUM_W-1:0]   ledr_q, ledr_d;
    logic [6:0]         hex1_q, hex1_d;
    logic [6:0]         hex0_q, hex0_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;

    logic [6:0]         tens_seg;
    logic [6:0]         units_seg;

    // Synchronise LOAD and keep a delayed copy of the last stage for edge detect.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from pre-edge values.
        if (RESET) begin
            sync_q     <= '0;
            load_dly_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], LOAD};
            load_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign load_rise = sync_q[SYNC_STAGES-1] & ~load_dly_q;

    // Both digits are decoded continuously; the patterns are only latched
    // into the output registers on the final conversion cycle.
    seg7_decoder u_seg_tens (
        .digit_i ({2'b00, tens_q}),
        .seg_o   (tens_seg)
    );

    seg7_decoder u_seg_units (
        .digit_i (rem_q[DIGIT_W-1:0]),
        .seg_o   (units_seg)
    );

    // FSM and datapath registers.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
            rem_q   <= '0;
            tens_q  <= '0;
            ledr_q  <= '0;
            hex1_q  <= HEX1_RST;
            hex0_q  <= SEG_0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tens_q  <= tens_d;
            ledr_q  <= ledr_d;
            hex1_q  <= hex1_d;
            hex0_q  <= hex0_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: capture in IDLE, subtract ten per cycle in CONV.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tens_d  = tens_q;
        ledr_d  = ledr_q;
        hex1_d  = hex1_q;
        hex0_d  = hex0_q;
        busy_d  = busy_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (load_rise) begin
                    rem_d   = SUM;
                    tens_d  = '0;
                    ledr_d  = SUM;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                // Edges arriving here are deliberately ignored, not queued.
                if (rem_q >= SUM_W'(10)) begin
                    rem_d  = rem_q - SUM_W'(10);
                    tens_d = tens_q + 2'd1;
                end else begin
`ifdef LEADING_ZERO_BLANK_EN
                    hex1_d = (tens_q == 2'd0) ? SEG_BLANK : tens_seg;
`else
                    hex1_d = tens_seg;
`endif
                    hex0_d  = units_seg;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign LEDR  = ledr_q;
    assign HEX1  = hex1_q;
    assign HEX0  = hex0_q;
    assign BUSY  = busy_q;
    assign VALID = valid_q;

endmodule
